// File: rtl/rr_arbiter_dec.sv
// rr_arbiter_dec: round-robin arbiter with binary-index winner and one-hot decode.
// Optional per-owner hold limit enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter_dec #(
  parameter int N = 32,
  parameter int IDXW = 5,
  parameter int HOLD_MAX = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant,
  output logic [IDXW-1:0] grant_idx,
  output logic            grant_valid
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d, ptr_q, ptr_d, nxt_idx, scan_ptr, pos, win_idx;
  logic [IDXW:0] sum;
  logic [N-1:0] grant_q, grant_d, req_m, rot;
  logic forced, rel, hold, win_found, regrant;
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign forced = state_q == BUSY && req[idx_q] && cnt_q == CW'(HOLD_MAX - 1);
  assign cnt_d = hold ? cnt_q + 1'b1 : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
`else
  assign forced = 1'b0;
`endif
  assign grant = grant_q;
  assign grant_idx = idx_q;
  assign grant_valid = state_q == BUSY;
  always_comb begin
    nxt_idx = idx_q == IDXW'(N - 1) ? '0 : idx_q + 1'b1;
    rel = state_q == BUSY && (!req[idx_q] || forced);
    hold = state_q == BUSY && !rel;
    scan_ptr = state_q == BUSY ? nxt_idx : ptr_q;
    // a timed-out owner sits out the scan and only wins back if nobody else asks
    req_m = forced ? req & ~(N'(1) << idx_q) : req;
    rot = N'({req_m, req_m} >> scan_ptr);
    pos = '0;
    for (int i = N - 1; i >= 0; i--)
      if (rot[i]) pos = IDXW'(i);
    win_found = |rot;
    sum = {1'b0, scan_ptr} + {1'b0, pos};
    win_idx = sum >= (IDXW+1)'(N) ? IDXW'(sum - (IDXW+1)'(N)) : IDXW'(sum);
    regrant = forced && !win_found;
    state_d = hold || regrant || win_found ? BUSY : IDLE;
    idx_d = hold || regrant ? idx_q : win_found ? win_idx : '0;
    ptr_d = rel ? nxt_idx : ptr_q;
    grant_d = state_d == BUSY ? N'(1) << idx_d : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      ptr_q <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
    end
endmodule

// File: tb/tb_rr_arbiter_dec.sv
// tb_rr_arbiter_dec: scoreboard bench for rr_arbiter_dec against a behavioural round-robin model.
module tb_rr_arbiter_dec;
  localparam int N = 32;
  localparam int IDXW = 5;
  localparam int HOLD_MAX = 8;
  typedef struct {
    logic valid;
    logic [IDXW-1:0] idx;
    logic [N-1:0] grant;
  } exp_t;
  logic clk = 0;
  logic rst_n;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [IDXW-1:0] grant_idx;
  logic grant_valid;
  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;
  bit m_busy;
  int m_idx, m_ptr, m_cnt;
  rr_arbiter_dec #(.N(N), .IDXW(IDXW), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic model_reset();
    m_busy = 0;
    m_idx = 0;
    m_ptr = 0;
    m_cnt = 0;
  endtask
  task automatic model(input logic [N-1:0] r);
    int p, w;
    bit frc;
    bit tmo;
`ifdef ARB_TIMEOUT_EN
    tmo = 1;
`else
    tmo = 0;
`endif
    frc = m_busy && r[m_idx] && tmo && m_cnt == HOLD_MAX - 1;
    if (m_busy && r[m_idx] && !frc) m_cnt++;
    else begin
      p = m_busy ? (m_idx + 1) % N : m_ptr;
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && r[(p + k) % N] && !(frc && (p + k) % N == m_idx)) w = (p + k) % N;
      if (w < 0 && frc) w = m_idx;
      m_ptr = p;
      m_cnt = 0;
      m_busy = w >= 0;
      m_idx = w >= 0 ? w : 0;
    end
  endtask
  task automatic step(input logic [N-1:0] r);
    exp_t e;
    @(negedge clk);
    req = r;
    model(r);
    e.valid = m_busy;
    e.idx = IDXW'(m_idx);
    e.grant = m_busy ? N'(64'd1 << m_idx) : '0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("grant_valid", 64'(grant_valid), 64'(e.valid));
    chk("grant_idx", 64'(grant_idx), 64'(e.idx));
    chk("grant", 64'(grant), 64'(e.grant));
  endtask
  initial begin
    logic [N-1:0] r;
    rst_n = 0;
    req = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_valid", 64'(grant_valid), 64'd0);
    rst_n = 1;
    repeat (5) step('0);
    step(32'h0000_0010);
    chk("t2_idx", 64'(grant_idx), 64'd4);
    chk("t2_grant", 64'(grant), 64'h10);
    step('0);
    chk("t2_idle", 64'(grant_valid), 64'd0);
    repeat (3) step(32'h8000_0021);
    chk("t3_first", 64'(grant_idx), 64'd5);
    repeat (2) step(32'h8000_0001);
    chk("t3_second", 64'(grant_idx), 64'd31);
    step(32'h0000_0001);
    chk("t3_third", 64'(grant_idx), 64'd0);
    step('0);
    step(32'h8000_0000);
    chk("t4_owner", 64'(grant_idx), 64'd31);
    step(32'h0000_0003);
    chk("t4_wrap", 64'(grant_idx), 64'd0);
    step(32'h0000_0002);
    chk("t4_next", 64'(grant_idx), 64'd1);
    step(32'h0000_0080);
    chk("t5_owner", 64'(grant_idx), 64'd7);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("t5_async_grant", 64'(grant), 64'd0);
    chk("t5_async_valid", 64'(grant_valid), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    step(32'h0000_0180);
    chk("t5_ptr0", 64'(grant_idx), 64'd7);
    step('0);
    r = '0;
    for (int c = 0; c < 300; c++) begin
      r = r ^ ($urandom & $urandom & $urandom);
      step(r);
    end
`ifdef ARB_TIMEOUT_EN
    step('0);
    for (int c = 0; c < 40; c++) step(32'h3);
    step('0);
    for (int c = 0; c < 30; c++) step(32'h1);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end
endmodule
